// File: rtl/par_fir_pkg.sv
// Shared constants and helpers for the block-parallel FIR: width helpers,
// default low-pass coefficient table and the round/saturate function.
package par_fir_pkg;

  localparam int DEF_TAPS   = 102;
  localparam int DEF_COEF_W = 32;
  localparam int SAT_W      = 128;

  function automatic int addr_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  localparam int DEF_ADDR_W = addr_w(DEF_TAPS);
  localparam int DEF_ACC_W  = acc_w(32, DEF_COEF_W, DEF_TAPS);

  typedef logic signed [DEF_COEF_W-1:0] def_coef_t [DEF_TAPS];

  // Triangular (Bartlett) low-pass in Q1.31, scaled so the taps sum to ~1.0.
  function automatic def_coef_t build_def_coef();
    def_coef_t c;
    int tri_w;
    for (int t = 0; t < DEF_TAPS; t++) begin
      tri_w = (t + 1 < DEF_TAPS - t) ? t + 1 : DEF_TAPS - t;
      c[t] = DEF_COEF_W'(tri_w * 809755);
    end
    return c;
  endfunction

  localparam def_coef_t DEF_COEF = build_def_coef();

  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] acc,
    input int                       shift,
    input int                       out_w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = 1;
    r   = acc;
    if (shift > 0) r = (r + (one <<< (shift - 1))) >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -(one <<< (out_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/par_fir_lane.sv
// One output lane: registered tap products, then summed, rounded, saturated
// and registered. The output register only loads on valid stage-2 cycles.
module par_fir_lane
  import par_fir_pkg::*;
#(
  parameter int NUM_TAPS = 102,
  parameter int DATA_W   = 32,
  parameter int COEF_W   = 32,
  parameter int OUT_W    = 32,
  parameter int SHIFT    = 31,
  parameter int ACC_W    = DATA_W + COEF_W + $clog2(NUM_TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prod_en,
  input  logic                       sum_en,
  input  logic [NUM_TAPS*DATA_W-1:0] win,
  input  logic [NUM_TAPS*COEF_W-1:0] coef,
  output logic [OUT_W-1:0]           y
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [SAT_W-1:0]  sat;
  logic [OUT_W-1:0]         y_q;
  logic [OUT_W-1:0]         y_d;

  always_comb begin
    for (int t = 0; t < NUM_TAPS; t++) begin
      prod_d[t] = prod_q[t];
      if (prod_en) begin
        prod_d[t] = $signed(win[t*DATA_W +: DATA_W]) * $signed(coef[t*COEF_W +: COEF_W]);
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int t = 0; t < NUM_TAPS; t++) acc = acc + ACC_W'(prod_q[t]);
    sat = sat_round(SAT_W'(acc), SHIFT, OUT_W);
    y_d = sum_en ? sat[OUT_W-1:0] : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TAPS; t++) prod_q[t] <= '0;
      y_q <= '0;
    end else begin
      for (int t = 0; t < NUM_TAPS; t++) prod_q[t] <= prod_d[t];
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/par_fir_block.sv
// L-lane block-parallel FIR with valid gating, runtime coefficient writes,
// sync clear and a fixed two-stage pipeline.
module par_fir_block
  import par_fir_pkg::*;
#(
  parameter int L        = 3,
  parameter int NUM_TAPS = 102,
  parameter int DATA_W   = 32,
  parameter int COEF_W   = 32,
  parameter int OUT_W    = 32,
  parameter int SHIFT    = 31,
  parameter int ACC_W    = DATA_W + COEF_W + $clog2(NUM_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [L*DATA_W-1:0]           x_in,
  input  logic                          clear,
  input  logic                          coef_we,
  input  logic [addr_w(NUM_TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]             coef_wdata,
  output logic                          out_valid,
  output logic [L*OUT_W-1:0]            y_out
);

  // Window = current L samples plus NUM_TAPS-1 retained ones, newest at 0.
  localparam int HIST_N = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;
  localparam int EXT_N  = L + HIST_N;

  logic [DATA_W-1:0] hist_q [HIST_N];
  logic [DATA_W-1:0] hist_d [HIST_N];
  logic [DATA_W-1:0] ext    [EXT_N];
  logic [COEF_W-1:0] coef_q [NUM_TAPS];
  logic [COEF_W-1:0] coef_d [NUM_TAPS];
  logic [NUM_TAPS*COEF_W-1:0] coef_flat;
  logic v1_q, v1_d, v2_q, v2_d;
  logic accept;

  assign accept = in_valid & ~clear;

  always_comb begin
    for (int m = 0; m < L; m++) ext[m] = x_in[(L-1-m)*DATA_W +: DATA_W];
    for (int m = 0; m < HIST_N; m++) ext[L+m] = hist_q[m];
  end

  always_comb begin
    for (int i = 0; i < HIST_N; i++) begin
      hist_d[i] = hist_q[i];
      if (clear)       hist_d[i] = '0;
      else if (accept) hist_d[i] = ext[i];
    end
    coef_d = coef_q;
    if (coef_we && int'(coef_addr) < NUM_TAPS) coef_d[coef_addr] = coef_wdata;
    v1_d = accept;
    v2_d = v1_q & ~clear;
    for (int t = 0; t < NUM_TAPS; t++) coef_flat[t*COEF_W +: COEF_W] = coef_q[t];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
      for (int t = 0; t < NUM_TAPS; t++) coef_q[t] <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      coef_q <= coef_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
    end
  end

  assign out_valid = v2_q;

  for (genvar j = 0; j < L; j++) begin : g_lane
    logic [NUM_TAPS*DATA_W-1:0] win;

    // Lane j's current sample sits at ext[L-1-j]; older taps follow it.
    always_comb begin
      for (int t = 0; t < NUM_TAPS; t++) win[t*DATA_W +: DATA_W] = ext[L-1-j+t];
    end

    par_fir_lane #(
      .NUM_TAPS(NUM_TAPS),
      .DATA_W  (DATA_W),
      .COEF_W  (COEF_W),
      .OUT_W   (OUT_W),
      .SHIFT   (SHIFT),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .prod_en(accept),
      .sum_en (v1_q & ~clear),
      .win    (win),
      .coef   (coef_flat),
      .y      (y_out[j*OUT_W +: OUT_W])
    );
  end

endmodule
